// File: rtl/caeser_pkg.sv
// Shared constants, FSM state type and group-count helper for the inverse Caesar layer.
package caeser_pkg;
    localparam int BLOCK_W     = 128;
    localparam int BYTE_W      = 8;
    localparam int NBYTES      = 16;
    localparam int KEYBYTE_MSB = 127;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int num_groups(input int bytes_per_cyc);
        return NBYTES / bytes_per_cyc;
    endfunction
endpackage

// File: rtl/caeser_inv_seq_if.sv
// Input/output valid-ready bus of the inverse Caesar block.
interface caeser_inv_seq_if;
    import caeser_pkg::*;

    logic               in_valid;
    logic               in_ready;
    logic [BLOCK_W-1:0] in_data;
    logic [BLOCK_W-1:0] key;
    logic               out_valid;
    logic               out_ready;
    logic [BLOCK_W-1:0] out_data;

    modport master (
        output in_valid, in_data, key, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, key, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/caeser_inv_seq_byte_sub.sv
// Single-byte mod-256 subtract of the key byte; the borrow is dropped.
module caeser_byte_sub
    import caeser_pkg::*;
(
    input  logic [BYTE_W-1:0] byte_i,
    input  logic [BYTE_W-1:0] key_i,
    output logic [BYTE_W-1:0] byte_o
);
    assign byte_o = byte_i - key_i;
endmodule

// File: rtl/caeser_inv_seq.sv
// Iterative inverse Caesar: subtracts the key's top byte from every block byte,
// BYTES_PER_CYC bytes per clock starting at byte 15, then holds the result for downstream.
module caeser_inv_seq
    import caeser_pkg::*;
#(
    parameter int BYTES_PER_CYC = 4
) (
    input  logic             clk,
    input  logic             rst,
    caeser_inv_seq_if.slave  bus
);
    localparam int N     = num_groups(BYTES_PER_CYC);
    localparam int GRP_W = BYTES_PER_CYC * BYTE_W;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

    if (BYTES_PER_CYC != 1 && BYTES_PER_CYC != 2 && BYTES_PER_CYC != 4 &&
        BYTES_PER_CYC != 8 && BYTES_PER_CYC != 16) begin : g_bad_param
        $error("caeser_inv_seq: BYTES_PER_CYC must be 1, 2, 4, 8 or 16");
    end

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [BLOCK_W-1:0] work_q;
    logic [BLOCK_W-1:0] work_d;
    logic [BYTE_W-1:0]  keyb_q;
    logic [BLOCK_W-1:0] out_data_q;
    logic               out_valid_q;
    logic [GRP_W-1:0]   grp;
    logic [GRP_W-1:0]   grp_sub;
    logic               unused_key_bits;

    // The working reg rotates left by one group per RUN edge, so the group being
    // processed always sits at the top and the bytes are back in place after N edges.
    assign grp = work_q[BLOCK_W-1 -: GRP_W];

    for (genvar b = 0; b < BYTES_PER_CYC; b++) begin : g_sub
        caeser_byte_sub u_sub (
            .byte_i (grp[b*BYTE_W +: BYTE_W]),
            .key_i  (keyb_q),
            .byte_o (grp_sub[b*BYTE_W +: BYTE_W])
        );
    end

    if (N == 1) begin : g_single
        assign work_d = grp_sub;
    end else begin : g_rot
        assign work_d = {work_q[BLOCK_W-GRP_W-1:0], grp_sub};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            work_q      <= '0;
            keyb_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        work_q  <= bus.in_data;
                        keyb_q  <= bus.key[KEYBYTE_MSB -: BYTE_W];
                        cnt_q   <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    work_q <= work_d;
                    cnt_q  <= cnt_q + 1'b1;
                    if (cnt_q == LAST_CNT) begin
                        out_data_q  <= work_d;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;

    assign unused_key_bits = ^bus.key[KEYBYTE_MSB-BYTE_W:0];
endmodule

// File: doc/caeser_inv_seq.md
Name: caeser_inv_seq

Overview:
- Decryption-side counterpart of the Caesar encryption layer.
- Accepts one 128-bit ciphertext block and a 128-bit key over a valid/ready handshake.
- Subtracts the key's top byte from every state byte, mod 256, iteratively, processing BYTES_PER_CYC bytes per clock.
- Presents the recovered block on a valid/ready output to the downstream decryption stage.

Parameters:
- BYTES_PER_CYC, 4, bytes processed per RUN cycle. Legal values: 1, 2, 4, 8, 16. Any other value is an elaboration error.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  upstream presents in_data and key.
- in_ready  output  1  block can accept a new input.
- in_data  input  128  ciphertext block; byte 15 = [127:120], byte 0 = [7:0].
- key  input  128  key; only key[127:120] is used.
- out_valid  output  1  out_data holds a completed result.
- out_ready  input  1  downstream accepts the result.
- out_data  output  128  plaintext block, registered.

Behaviour:
- Clock and reset: one clock (clk). Reset rst is asynchronous and active-high.
- Reset values: state = IDLE, out_valid = 0, out_data = 0, byte counter = 0, working regs = 0. in_ready = 1 from the first edge after rst deasserts.
- in_ready = (state == IDLE). It is decoded from registered state only; there is no combinational path from out_ready.
- IDLE:
  - On an edge with in_valid && in_ready: latch in_data into the working reg and key[127:120] into the key-byte reg, clear the counter, go to RUN.
  - Later changes to key or in_data do not affect the block in flight.
- RUN:
  - Each edge replaces BYTES_PER_CYC working bytes with (byte - keybyte) mod 256, i.e. 8-bit subtract with the borrow discarded.
  - Order: byte 15 downward. Cycle i covers bytes 15-i*B .. 16-(i+1)*B, where B = BYTES_PER_CYC.
  - Counter increments each edge.
  - On the edge that processes the last group: copy the full result to out_data, set out_valid = 1, go to DONE.
- DONE:
  - out_valid = 1. out_data is held stable until out_valid && out_ready is sampled high.
  - On that handshake edge: out_valid -> 0, go to IDLE.
  - out_data keeps its last value until the next completion.
- Latency:
  - N = 16 / BYTES_PER_CYC RUN edges; default N = 4.
  - out_valid rises on the N-th edge after the acceptance edge.
  - Throughput: one block per N+2 cycles when out_ready is held high.
  - No overlap: a new block is never accepted while RUN or DONE.
- Boundaries:
  - in_valid while not IDLE: ignored; upstream must hold it.
  - out_ready high with out_valid low: no effect.
  - Key byte 0x00: identity.
  - Wrap-around: 0x02 - 0x05 = 0xFD.
- Reset mid-operation (RUN or DONE): immediate abort, partial data discarded, out_valid drops asynchronously, outputs return to reset values.
- Bit-exact inverse: for any block X and key K, caeser_inv_seq(caeser-layer(X, K), K) = X.

Decomposition:
- Shared package (caeser_pkg):
  - BLOCK_W = 128, BYTE_W = 8, NBYTES = 16, KEYBYTE_MSB = 127.
  - State enum: IDLE, RUN, DONE.
  - Function/constant for N = NBYTES / BYTES_PER_CYC.
- Sub-module caeser_byte_sub: 8-bit in, 8-bit key, 8-bit out, mod-256 subtract. Instantiated BYTES_PER_CYC times on the muxed byte group.
- Top module holds the FSM, counter, working reg and output reg.

Test Plan:
- Basic decrypt, default parameter:
  - Stimulus: in_data = 0x000102030405060708090A0B0C0D0E0F, key = 0x05000000_00000000_00000000_00000000.
  - Required: out_data = 0xFBFCFDFEFF000102030405060708090A, with out_valid rising exactly 4 edges after acceptance.
- Key low bits ignored and key changed after acceptance:
  - Stimulus: key = 0x05FFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF at acceptance, then key switched to 0x99.. the next cycle.
  - Required: same result as the basic decrypt case.
- Round-trip against the encryption layer model:
  - Stimulus: X = 0x00112233445566778899AABBCCDDEEFF, key byte 0xA7; feed encrypt(X) into this block.
  - Required: out_data = X. Repeat with BYTES_PER_CYC = 1, 2, 8, 16 and check latency = 16, 8, 2, 1 edges.
- Backpressure:
  - Stimulus: out_ready held 0 for 10 cycles after out_valid rises.
  - Required: out_valid stays 1, out_data stable, in_ready stays 0; after out_ready = 1 for one edge, out_valid = 0 and in_ready = 1.
- Reset mid-operation:
  - Stimulus: assert rst during the 2nd RUN cycle, then release.
  - Required: out_valid = 0 and out_data = 0 immediately; in_ready = 1 after release; the next block decrypts correctly.
- Back-to-back traffic:
  - Stimulus: in_valid and out_ready held 1, 3 blocks streamed.
  - Required: 3 correct outputs, each separated by exactly N+2 cycles, no in_ready while busy.
